// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: mode encodings and pattern helpers.
package led_pkg;

  // Widest LED bank the pattern helpers are sized for.
  localparam int MAX_LEDS = 32;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_GRAY   = 2'd3
  } mode_e;

  // Binary-reflected Gray code of a binary value.
  function automatic logic [MAX_LEDS-1:0] gray_enc(input logic [MAX_LEDS-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Single set bit at position idx.
  function automatic logic [MAX_LEDS-1:0] onehot(input logic [4:0] idx);
    return {{(MAX_LEDS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/led_sequencer.sv
// LED pattern sequencer: binary up/down counter, bounce scanner and Gray
// counter, advanced by divider ticks (running) or step pulses (paused).
module led_sequencer
  import led_pkg::*;
#(
  parameter int LED_COUNT  = 6,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 run_i,
  input  logic                 step_i,
  input  logic                 clear_i,
  input  logic [1:0]           mode_i,
  output logic [1:0]           mode_o,
  output logic [LED_COUNT-1:0] led_o,
  output logic                 wrap_o
);

  if (LED_COUNT < 2 || LED_COUNT > MAX_LEDS) begin : g_bad_led_count
    $error("led_sequencer: LED_COUNT must be in 2..32");
  end

  localparam int PW = (LED_COUNT > 2) ? $clog2(LED_COUNT) : 1;
  localparam logic [PW-1:0]        POS_LAST = PW'(LED_COUNT - 1);
  localparam logic [PW-1:0]        POS_ONE  = PW'(1);
  localparam logic [LED_COUNT-1:0] CNT_ONE  = LED_COUNT'(1);
  localparam logic [LED_COUNT-1:0] LED_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [LED_COUNT-1:0] count_q, count_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 dir_q, dir_d;
  mode_e                mode_q, mode_d;
  logic [LED_COUNT-1:0] led_q, led_d;
  logic                 wrap_q, wrap_d;

  logic                 adv;
  logic                 do_init;
  mode_e                init_mode;
  mode_e                req_mode;
  logic [LED_COUNT-1:0] pattern;

  // Next-state: clear beats a mode change, which beats a normal step.
  always_comb begin
    count_d   = count_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    wrap_d    = 1'b0;
    do_init   = 1'b0;
    init_mode = mode_q;
    req_mode  = mode_e'(mode_i);
    adv       = run_i ? tick_i : step_i;

    if (clear_i) begin
      do_init = 1'b1;
    end else if (adv) begin
      if (req_mode != mode_q) begin
        mode_d    = req_mode;
        init_mode = req_mode;
        do_init   = 1'b1;
      end else begin
        unique case (mode_q)
          MODE_UP, MODE_GRAY: begin
            count_d = count_q + CNT_ONE;
            wrap_d  = &count_q;
          end
          MODE_DOWN: begin
            count_d = count_q - CNT_ONE;
            wrap_d  = ~|count_q;
          end
          MODE_BOUNCE: begin
            // Reverse at an end without dwelling there, so ends show once.
            if (!dir_q) begin
              if (pos_q == POS_LAST) begin
                dir_d = 1'b1;
                pos_d = pos_q - POS_ONE;
              end else begin
                pos_d = pos_q + POS_ONE;
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = 1'b0;
                pos_d = pos_q + POS_ONE;
              end else begin
                pos_d = pos_q - POS_ONE;
              end
            end
            // Every step moves pos, so landing on 0 means 1 -> 0.
            wrap_d = (pos_d == '0);
          end
          default: ;
        endcase
      end
    end

    if (do_init) begin
      unique case (init_mode)
        MODE_UP, MODE_GRAY: count_d = '0;
        MODE_DOWN:          count_d = '1;
        MODE_BOUNCE: begin
          pos_d = '0;
          dir_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Display pattern derived from the post-update state.
  always_comb begin
    pattern = count_d;
    unique case (mode_d)
      MODE_UP, MODE_DOWN: pattern = count_d;
      MODE_GRAY:          pattern = LED_COUNT'(gray_enc(MAX_LEDS'(count_d)));
      MODE_BOUNCE:        pattern = LED_COUNT'(onehot(5'(pos_d)));
      default:            pattern = count_d;
    endcase
    led_d = (ACTIVE_LOW != 0) ? ~pattern : pattern;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_UP;
      led_q   <= LED_OFF;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
    end
  end

  assign mode_o = mode_q;
  assign led_o  = led_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (LED_COUNT=6, ACTIVE_LOW=1).
module tb_led_sequencer;

  localparam int N = 6;
  localparam int MAXC = (1 << N) - 1;
  localparam int PERIOD_B = 2 * N - 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_i = 1'b0, run_i = 1'b0, step_i = 1'b0, clear_i = 1'b0;
  logic [1:0]   mode_i = 2'd0;
  logic [1:0]   mode_o;
  logic [N-1:0] led_o;
  logic         wrap_o;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  led_sequencer #(.LED_COUNT(N), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .run_i(run_i), .step_i(step_i),
    .clear_i(clear_i), .mode_i(mode_i), .mode_o(mode_o), .led_o(led_o),
    .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  // Reference: bounce position kept as a phase 0..PERIOD_B-1 around the cycle.
  typedef struct {
    int mode;
    int cnt;
    int ph;
    bit wrap;
  } mstate_t;

  mstate_t m = '{0, 0, 0, 1'b0};

  function automatic mstate_t init_mode(mstate_t s, int md);
    mstate_t r = s;
    r.mode = md;
    if (md == 1) r.cnt = MAXC;
    else if (md == 2) r.ph = 0;
    else r.cnt = 0;
    return r;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit tk, bit rn, bit st, bit cl, int mi);
    mstate_t r = s;
    bit a = rn ? tk : st;
    r.wrap = 1'b0;
    if (cl) r = init_mode(r, s.mode);
    else if (a && mi != s.mode) r = init_mode(r, mi);
    else if (a) begin
      if (s.mode == 1) begin
        r.cnt = (s.cnt + MAXC) % (MAXC + 1);
        r.wrap = (s.cnt == 0);
      end else if (s.mode == 2) begin
        r.ph = (s.ph + 1) % PERIOD_B;
        r.wrap = (r.ph == 0);
      end else begin
        r.cnt = (s.cnt + 1) % (MAXC + 1);
        r.wrap = (s.cnt == MAXC);
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_led(mstate_t s);
    int pat;
    int p;
    if (s.mode == 2) begin
      p = (s.ph < N) ? s.ph : PERIOD_B - s.ph;
      pat = 1 << p;
    end else if (s.mode == 3) pat = s.cnt ^ (s.cnt >> 1);
    else pat = s.cnt;
    return N'(~pat);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{0, 0, 0, 1'b0};
    else m <= model_next(m, tick_i, run_i, step_i, clear_i, int'(mode_i));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the reference model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_led", 32'(led_o), 32'(exp_led(m)));
      chk("model_mode", 32'(mode_o), 32'(m.mode));
      chk("model_wrap", 32'(wrap_o), 32'(m.wrap));
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge.
  task automatic cyc(input bit tk, input bit rn, input bit st, input bit cl, input logic [1:0] md);
    tick_i = tk; run_i = rn; step_i = st; clear_i = cl; mode_i = md;
    @(posedge clk);
    #1;
    tick_i = 1'b0; step_i = 1'b0; clear_i = 1'b0;
  endtask

  int wraps;
  int guard;
  int bpos[10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", 32'(led_o), 32'h3f);
    chk("rst_mode", 32'(mode_o), 32'd0);
    chk("rst_wrap", 32'(wrap_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // UP: 64 ticks, a single wrap on the last
    wraps = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc(1, 1, 0, 0, 2'd0);
      if (wrap_o) wraps++;
      if (i == 1)  chk("up_first", 32'(led_o), 32'h3e);
      if (i == 63) chk("up_all_on", 32'(led_o), 32'h00);
    end
    chk("up_wrap_now", 32'(wrap_o), 32'd1);
    chk("up_wrap_count", 32'(wraps), 32'd1);
    chk("up_back_zero", 32'(led_o), 32'h3f);
    cyc(0, 1, 0, 0, 2'd0);
    chk("up_wrap_one_cycle", 32'(wrap_o), 32'd0);

    // BOUNCE: first tick only switches mode
    cyc(1, 1, 0, 0, 2'd2);
    chk("bnc_mode", 32'(mode_o), 32'd2);
    chk("bnc_init", 32'(led_o), 32'h3e);
    chk("bnc_init_wrap", 32'(wrap_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 0, 2'd2);
      chk("bnc_led", 32'(led_o), 32'(6'(~(6'd1 << bpos[i]))));
      chk("bnc_wrap", 32'(wrap_o), (i == 9) ? 32'd1 : 32'd0);
    end

    // GRAY paused: step switches mode, then three steps; ticks ignored
    cyc(0, 0, 1, 0, 2'd3);
    chk("gray_mode", 32'(mode_o), 32'd3);
    chk("gray_init", 32'(led_o), 32'h3f);
    cyc(1, 0, 0, 0, 2'd3);
    chk("gray_tick_ignored", 32'(led_o), 32'h3f);
    cyc(0, 0, 1, 0, 2'd3);
    chk("gray_1", 32'(led_o), 32'h3e);
    cyc(1, 0, 0, 0, 2'd3);
    cyc(0, 0, 1, 0, 2'd3);
    chk("gray_2", 32'(led_o), 32'h3c);
    cyc(0, 0, 1, 0, 2'd3);
    chk("gray_3", 32'(led_o), 32'h3d);
    cyc(0, 1, 1, 0, 2'd3);
    chk("step_ignored_run", 32'(led_o), 32'h3d);

    // DOWN: step loads all ones, next step 62
    cyc(0, 0, 1, 0, 2'd1);
    chk("down_init", 32'(led_o), 32'h00);
    cyc(0, 0, 1, 0, 2'd1);
    chk("down_62", 32'(led_o), 32'h01);

    // Clear wins over advance and mode change at count=10
    guard = 0;
    while (led_o !== 6'(~6'd10) && guard < 100) begin
      cyc(0, 0, 1, 0, 2'd1);
      guard++;
    end
    chk("down_reach_10", 32'(led_o), 32'(6'(~6'd10)));
    cyc(0, 0, 1, 1, 2'd2);
    chk("clr_led", 32'(led_o), 32'h00);
    chk("clr_mode", 32'(mode_o), 32'd1);
    chk("clr_wrap", 32'(wrap_o), 32'd0);

    // Mid-run async reset in BOUNCE at pos=3 heading down
    cyc(1, 1, 0, 0, 2'd2);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 2'd2);
    chk("pre_rst_pos3", 32'(led_o), 32'h37);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led_o), 32'h3f);
    chk("async_rst_mode", 32'(mode_o), 32'd0);
    chk("async_rst_wrap", 32'(wrap_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 0, 0, 2'd0);
    chk("post_rst_up1", 32'(led_o), 32'h3e);
    chk("post_rst_mode", 32'(mode_o), 32'd0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : mode_o);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
